// File: rtl/pwm_multich_gen_if.sv
// Control and status bundle between the config logic and pwm_multich_gen.
// The master drives the run controls and new settings; the slave returns the pad-side outputs.
interface pwm_multich_gen_if #(
  parameter int CHANNELS = 3,
  parameter int RES      = 8,
  parameter int PRESC_W  = 16
);
  logic                     ena;
  logic [PRESC_W-1:0]       prescale;
  logic [RES-1:0]           period_in;
  logic [CHANNELS*RES-1:0]  duty_in;
  logic                     mode_in;
  logic                     load;
  logic [CHANNELS-1:0]      pwm_out;
  logic                     period_start;
  logic                     load_pending;

  modport master (
    output ena, prescale, period_in, duty_in, mode_in, load,
    input  pwm_out, period_start, load_pending
  );

  modport slave (
    input  ena, prescale, period_in, duty_in, mode_in, load,
    output pwm_out, period_start, load_pending
  );
endinterface

// File: rtl/pwm_multich_gen.sv
// Multi-channel PWM generator: a shared prescaler and period counter drive CHANNELS compare outputs,
// with settings double-buffered in a shadow copy and applied only on a period boundary.
//
// dir state | meaning
// DIR_UP    | counter incrementing (edge mode always, center mode rising half)
// DIR_DN    | center mode falling half, counting back toward 0
module pwm_multich_gen #(
  parameter int                    CHANNELS   = 3,
  parameter int                    RES        = 8,
  parameter int                    PRESC_W    = 16,
  parameter logic [RES-1:0]        PERIOD_RST = 8'd255,
  parameter logic [CHANNELS-1:0]   POLARITY   = 3'b000
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_multich_gen_if.slave    bus
);

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

  logic [PRESC_W-1:0]       psc_q, psc_d;
  logic [RES-1:0]           cnt_q, cnt_d, cnt_nxt;
  logic [0:0]               dir_q, dir_d, dir_nxt;
  logic [RES-1:0]           per_q, per_d, per_sh_q, per_sh_d;
  logic [CHANNELS*RES-1:0]  duty_q, duty_d, duty_sh_q, duty_sh_d;
  logic                     mode_q, mode_d, mode_sh_q, mode_sh_d;
  logic                     pend_q, pend_d;
  logic [CHANNELS-1:0]      pwm_q, pwm_d;
  logic                     ps_q, ps_d;
  logic                     psc_wrap, tick, boundary;

  // Compare is >= so a prescale reduced below the running count still wraps on the next step.
  always_comb begin
    psc_wrap = (psc_q >= bus.prescale);
    tick     = bus.ena & psc_wrap;
    psc_d    = psc_q;
    if (bus.ena) begin
      psc_d = psc_wrap ? '0 : psc_q + 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    dir_nxt = dir_q;
    if (!mode_q) begin
      cnt_nxt = (cnt_q >= per_q) ? '0 : cnt_q + 1'b1;
      dir_nxt = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_q) begin
        cnt_nxt = (per_q == '0) ? '0 : cnt_q - 1'b1;
        dir_nxt = DIR_DN;
      end else begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end else begin
      cnt_nxt = cnt_q - 1'b1;
    end
    if (cnt_nxt == '0) begin
      dir_nxt = DIR_UP;
    end
    boundary = tick & (cnt_nxt == '0);
  end

  // A load landing on the boundary bypasses the shadow so it never shows as pending.
  always_comb begin
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    mode_sh_d = mode_sh_q;
    per_d     = per_q;
    duty_d    = duty_q;
    mode_d    = mode_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    if (bus.load) begin
      per_sh_d  = bus.period_in;
      duty_sh_d = bus.duty_in;
      mode_sh_d = bus.mode_in;
      pend_d    = 1'b1;
    end
    if (tick) begin
      cnt_d = cnt_nxt;
      dir_d = dir_nxt;
    end
    if (boundary) begin
      pend_d = 1'b0;
      if (bus.load) begin
        per_d  = bus.period_in;
        duty_d = bus.duty_in;
        mode_d = bus.mode_in;
      end else if (pend_q) begin
        per_d  = per_sh_q;
        duty_d = duty_sh_q;
        mode_d = mode_sh_q;
      end
    end
    ps_d = boundary;
  end

  always_comb begin
    pwm_d = POLARITY;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.ena) begin
        pwm_d[i] = (cnt_q < duty_q[i*RES +: RES]) ^ POLARITY[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q     <= '0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      per_q     <= PERIOD_RST;
      per_sh_q  <= PERIOD_RST;
      duty_q    <= '0;
      duty_sh_q <= '0;
      mode_q    <= 1'b0;
      mode_sh_q <= 1'b0;
      pend_q    <= 1'b0;
      pwm_q     <= POLARITY;
      ps_q      <= 1'b0;
    end else begin
      psc_q     <= psc_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      per_q     <= per_d;
      per_sh_q  <= per_sh_d;
      duty_q    <= duty_d;
      duty_sh_q <= duty_sh_d;
      mode_q    <= mode_d;
      mode_sh_q <= mode_sh_d;
      pend_q    <= pend_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.load_pending = pend_q;

endmodule

// File: tb/tb_pwm_multich_gen.sv
// Directed bench for pwm_multich_gen with channel 1 inverted; ch1 duty is 0 and ch2 duty is 10 throughout,
// so the upper two output bits read 2'b11 while running and ch0 carries the pattern under test.
module tb_pwm_multich_gen;

  localparam logic [2:0] POL = 3'b010;

  logic clk;
  logic rst_n;

  pwm_multich_gen_if #(.CHANNELS(3), .RES(8), .PRESC_W(16)) bus ();

  pwm_multich_gen #(
    .CHANNELS(3), .RES(8), .PRESC_W(16), .PERIOD_RST(8'd255), .POLARITY(POL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        ena;
    logic [7:0]  p;
    logic [7:0]  d0;
    logic        mode;
    logic [15:0] psc;
    logic [2:0]  exp_pwm;
    logic        exp_ps;
    logic        exp_lp;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(int n, logic ld, logic ena, logic [7:0] p, logic [7:0] d0, logic mode,
                              logic [15:0] psc, logic [2:0] pwm, logic ps, logic lp);
    vec_t v;
    v.ld = ld; v.ena = ena; v.p = p; v.d0 = d0; v.mode = mode; v.psc = psc;
    v.exp_pwm = pwm; v.exp_ps = ps; v.exp_lp = lp;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v);
    bus.load      = v.ld;
    bus.ena       = v.ena;
    bus.period_in = v.p;
    bus.duty_in   = {8'd10, 8'd0, v.d0};
    bus.mode_in   = v.mode;
    bus.prescale  = v.psc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int first_ps;
    int ps_count;
    int bad_pwm;

    // Cycle k is sampled 1ns after the k-th edge following the first observed boundary;
    // each record is checked at its cycle and its inputs then take effect on the next edge.
    add(3,  0,1,9,3,0,0, 3'b111,0,0);
    add(6,  0,1,9,3,0,0, 3'b110,0,0);
    add(1,  0,1,9,3,0,0, 3'b110,1,0);   // k10
    add(3,  0,1,9,3,0,0, 3'b111,0,0);
    add(6,  0,1,9,3,0,0, 3'b110,0,0);
    add(1,  0,1,9,3,0,0, 3'b110,1,0);   // k20
    add(1,  0,1,9,3,0,0, 3'b111,0,0);
    add(1,  1,1,9,6,0,0, 3'b111,0,0);   // k22: first load at cnt=2
    add(1,  1,1,9,7,0,0, 3'b111,0,1);   // k23: second load overwrites
    add(6,  0,1,9,7,0,0, 3'b110,0,1);
    add(1,  0,1,9,7,0,0, 3'b110,1,0);   // k30: duty 7 applied
    add(7,  0,1,9,7,0,0, 3'b111,0,0);
    add(2,  0,1,9,7,0,0, 3'b110,0,0);
    add(1,  0,1,9,7,0,0, 3'b110,1,0);   // k40
    add(7,  0,1,9,7,0,0, 3'b111,0,0);
    add(1,  0,1,9,7,0,0, 3'b110,0,0);
    add(1,  1,1,4,1,0,0, 3'b110,0,0);   // k49: load lands on boundary edge
    add(1,  0,1,4,1,0,0, 3'b110,1,0);   // k50
    add(1,  0,1,4,1,0,0, 3'b111,0,0);
    add(3,  0,1,4,1,0,0, 3'b110,0,0);
    add(1,  0,1,4,1,0,0, 3'b110,1,0);   // k55: P=4 period is 5 clks
    add(1,  0,1,4,1,0,0, 3'b111,0,0);
    add(1,  1,1,4,2,1,0, 3'b110,0,0);   // k57: load center mode
    add(2,  0,1,4,2,1,0, 3'b110,0,1);
    add(1,  0,1,4,2,1,1, 3'b110,1,0);   // k60: prescale=1 from here
    add(4,  0,1,4,2,1,1, 3'b111,0,0);
    add(10, 0,1,4,2,1,1, 3'b110,0,0);
    add(1,  0,1,4,2,1,1, 3'b111,0,0);
    add(1,  0,1,4,2,1,1, 3'b111,1,0);   // k76
    add(4,  0,1,4,2,1,1, 3'b111,0,0);
    add(10, 0,1,4,2,1,1, 3'b110,0,0);
    add(1,  0,1,4,2,1,1, 3'b111,0,0);
    add(1,  0,1,4,2,1,1, 3'b111,1,0);   // k92
    add(2,  0,1,4,2,1,1, 3'b111,0,0);
    add(1,  0,0,4,2,1,1, 3'b111,0,0);   // k95: drop ena
    add(3,  0,0,4,2,1,1, 3'b010,0,0);
    add(1,  0,1,4,2,1,1, 3'b010,0,0);   // k99: restore ena
    add(1,  0,1,4,2,1,1, 3'b111,0,0);
    add(10, 0,1,4,2,1,1, 3'b110,0,0);
    add(1,  0,1,4,2,1,1, 3'b111,0,0);
    add(1,  0,1,4,2,1,1, 3'b111,1,0);   // k112: boundary delayed 4 clks by the freeze
    add(1,  1,1,9,3,0,1, 3'b111,0,0);   // k113: load so a pending state exists before reset

    bus.load = 1'b0; bus.ena = 1'b0; bus.prescale = '0;
    bus.period_in = '0; bus.duty_in = '0; bus.mode_in = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #5;
    check("reset pwm_out", {29'd0, bus.pwm_out}, {29'd0, POL});
    check("reset period_start", {31'd0, bus.period_start}, 32'd0);
    check("reset load_pending", {31'd0, bus.load_pending}, 32'd0);

    step();
    rst_n = 1'b1;
    step();

    bus.load = 1'b1; bus.period_in = 8'd9; bus.duty_in = {8'd10, 8'd0, 8'd3}; bus.mode_in = 1'b0;
    step();
    bus.load = 1'b0;
    check("load while disabled pending", {31'd0, bus.load_pending}, 32'd1);
    check("disabled pwm_out", {29'd0, bus.pwm_out}, {29'd0, POL});

    bus.ena = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (bus.period_start) found = 1'b1;
    end
    check("first boundary seen", {31'd0, found}, 32'd1);

    for (int k = 0; k < tbl.size(); k++) begin
      step();
      check($sformatf("k%0d pwm_out", k + 1), {29'd0, bus.pwm_out}, {29'd0, tbl[k].exp_pwm});
      check($sformatf("k%0d period_start", k + 1), {31'd0, bus.period_start}, {31'd0, tbl[k].exp_ps});
      check($sformatf("k%0d load_pending", k + 1), {31'd0, bus.load_pending}, {31'd0, tbl[k].exp_lp});
      apply(tbl[k]);
    end

    step();
    bus.load = 1'b0; bus.ena = 1'b1; bus.prescale = 16'd3;
    check("pending before reset", {31'd0, bus.load_pending}, 32'd1);
    check("pwm before reset", {29'd0, bus.pwm_out}, 32'd7);
    #3 rst_n = 1'b0;
    #1;
    check("mid-period reset pwm_out", {29'd0, bus.pwm_out}, {29'd0, POL});
    check("mid-period reset load_pending", {31'd0, bus.load_pending}, 32'd0);
    check("mid-period reset period_start", {31'd0, bus.period_start}, 32'd0);
    step();
    rst_n = 1'b1;

    first_ps = 0; ps_count = 0; bad_pwm = 0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (bus.period_start) begin
        ps_count++;
        if (first_ps == 0) first_ps = i;
      end
      if (bus.pwm_out !== POL) bad_pwm++;
    end
    check("post-reset first boundary cycle", first_ps, 32'd1024);
    check("post-reset boundary count", ps_count, 32'd1);
    check("post-reset pwm stays inactive", bad_pwm, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
